// File: rtl/sdio_bus_pkg.sv
// Shared definitions for the SDIO system-bus arbiter.
//   AW_DEF          default byte-address width of the bus
//   M_DMA / M_HOST  master id encoding (m0 = sdio_top DMA, m1 = host test master)
//   ST_IDLE/ST_OWN  arbiter FSM state constants
//   pick_winner()   arbitration decision used when leaving IDLE
package sdio_bus_pkg;

    localparam int AW_DEF = 17;

    localparam logic M_DMA  = 1'b0;
    localparam logic M_HOST = 1'b1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    // Fixed priority favours m0; otherwise the master that did not win last time.
    function automatic logic pick_winner(
        input logic req0,
        input logic req1,
        input logic last_win,
        input logic prio0
    );
        logic win;
        if (req0 && req1) begin
            win = prio0 ? M_DMA : ~last_win;
        end else if (req1) begin
            win = M_HOST;
        end else begin
            win = M_DMA;
        end
        return win;
    endfunction

endpackage

// File: rtl/sdio_tag_fifo.sv
// Read-tag FIFO: remembers which master issued each outstanding read so the
// returning data can be steered back to it.
//   clk, rst   clock, asynchronous active-high reset
//   push, din  enqueue one tag (ignored while full)
//   pop        dequeue the head tag (ignored while empty)
//   dout       head tag, combinational
//   full/empty status; count = tags held (0..DEPTH)
module sdio_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       din,
    input  logic                       pop,
    output logic                       dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic            mem [DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];
    // Push is judged against the pre-pop occupancy: a full FIFO refuses a push
    // even if a pop happens in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/sdio_bus_arb.sv
// Two-master arbiter for the 8-bit SDIO system bus. m0 (DMA) and m1 (host)
// share one memory slave; the owner's request is forwarded combinationally and
// read data is routed back through a tag FIFO that records the issuing master.
//   bus_clk, rst                      clock, asynchronous active-high reset
//   mX_rd/mX_wr/mX_addr/mX_wdata      master requests (held until mX_ready)
//   mX_ready                          master beat accepted this cycle
//   mX_rdata/mX_rdata_ready           returned read data (broadcast) and its strobe
//   s_rd/s_wr/s_addr/s_wdata          slave request
//   s_ready/s_rdata/s_rdata_ready     slave handshake and read return
//   grant_id/busy                     current owner and ownership flag
//   outst_cnt                         reads in flight
//   err                               sticky: [0] orphan read data, [1] rd&wr together
module sdio_bus_arb
    import sdio_bus_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int BURST_MAX = 16,
    parameter int OUTST     = 4,
    parameter int PRIO0     = 0
) (
    input  logic                    bus_clk,
    input  logic                    rst,
    input  logic                    m0_rd,
    input  logic                    m0_wr,
    input  logic [AW-1:0]           m0_addr,
    input  logic [7:0]              m0_wdata,
    output logic                    m0_ready,
    output logic [7:0]              m0_rdata,
    output logic                    m0_rdata_ready,
    input  logic                    m1_rd,
    input  logic                    m1_wr,
    input  logic [AW-1:0]           m1_addr,
    input  logic [7:0]              m1_wdata,
    output logic                    m1_ready,
    output logic [7:0]              m1_rdata,
    output logic                    m1_rdata_ready,
    output logic                    s_rd,
    output logic                    s_wr,
    output logic [AW-1:0]           s_addr,
    output logic [7:0]              s_wdata,
    input  logic                    s_ready,
    input  logic [7:0]              s_rdata,
    input  logic                    s_rdata_ready,
    output logic                    grant_id,
    output logic                    busy,
    output logic [$clog2(OUTST):0]  outst_cnt,
    output logic [1:0]              err
);

    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [BW-1:0] BMAX_CNT = BW'(BURST_MAX);

    logic [1:0]     rd_vec;
    logic [1:0]     wr_vec;
    logic [1:0]     req_vec;
    logic [AW-1:0]  addr_vec  [2];
    logic [7:0]     wdata_vec [2];
    logic [1:0]     ready_vec;
    logic [1:0]     rdata_rdy_vec;

    logic [0:0]     state_reg, state_next;
    logic           grant_id_reg, grant_id_next;
    logic           last_win_reg, last_win_next;
    logic [BW-1:0]  beat_cnt_reg, beat_cnt_next;
    logic [1:0]     err_reg, err_next;

    logic           own_active;
    logic           owner;
    logic           o_rd, o_wr, o_req, other_req;
    logic           burst_done, hold;
    logic           accepted;
    logic           fifo_full, fifo_empty, fifo_head;

    assign rd_vec       = {m1_rd, m0_rd};
    assign wr_vec       = {m1_wr, m0_wr};
    assign req_vec      = rd_vec | wr_vec;
    assign addr_vec[0]  = m0_addr;
    assign addr_vec[1]  = m1_addr;
    assign wdata_vec[0] = m0_wdata;
    assign wdata_vec[1] = m1_wdata;

    assign own_active = (state_reg == ST_OWN);
    assign owner      = grant_id_reg;
    assign o_rd       = rd_vec[owner];
    assign o_wr       = wr_vec[owner];
    assign o_req      = req_vec[owner];
    assign other_req  = req_vec[~owner];

    // Burst quota used up while the other master waits: stop forwarding so no
    // beat beyond the quota is accepted, and hand over on this edge.
    assign burst_done = (beat_cnt_reg == BMAX_CNT);
    assign hold       = burst_done & other_req;

    // Writes win over reads on a rd&wr collision; reads also stall on a full FIFO.
    assign s_wr    = own_active & o_wr & ~hold;
    assign s_rd    = own_active & o_rd & ~o_wr & ~fifo_full & ~hold;
    assign s_addr  = own_active ? addr_vec[owner]  : '0;
    assign s_wdata = own_active ? wdata_vec[owner] : '0;

    assign accepted = s_ready & (s_rd | s_wr);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mst
            assign ready_vec[gi]     = accepted & (owner == 1'(gi));
            assign rdata_rdy_vec[gi] = s_rdata_ready & ~fifo_empty & (fifo_head == 1'(gi));
        end
    endgenerate

    assign m0_ready       = ready_vec[0];
    assign m1_ready       = ready_vec[1];
    assign m0_rdata_ready = rdata_rdy_vec[0];
    assign m1_rdata_ready = rdata_rdy_vec[1];
    assign m0_rdata       = s_rdata;
    assign m1_rdata       = s_rdata;

    assign grant_id = grant_id_reg;
    assign busy     = own_active;
    assign err      = err_reg;

    sdio_tag_fifo #(
        .DEPTH (OUTST)
    ) u_tag_fifo (
        .clk   (bus_clk),
        .rst   (rst),
        .push  (accepted & s_rd),
        .din   (owner),
        .pop   (s_rdata_ready),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (outst_cnt)
    );

    always_comb begin
        state_next    = state_reg;
        grant_id_next = grant_id_reg;
        last_win_next = last_win_reg;
        beat_cnt_next = beat_cnt_reg;
        err_next      = err_reg | {own_active & o_rd & o_wr, s_rdata_ready & fifo_empty};

        case (state_reg)
            ST_IDLE: begin
                if (|req_vec) begin
                    state_next    = ST_OWN;
                    grant_id_next = pick_winner(req_vec[0], req_vec[1], last_win_reg, PRIO0 != 0);
                    last_win_next = grant_id_next;
                    beat_cnt_next = '0;
                end
            end
            ST_OWN: begin
                if (!o_req) begin
                    // Owner let go: pass straight to a waiting master, else go idle.
                    beat_cnt_next = '0;
                    if (other_req) begin
                        grant_id_next = ~owner;
                        last_win_next = ~owner;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (hold) begin
                    grant_id_next = ~owner;
                    last_win_next = ~owner;
                    beat_cnt_next = '0;
                end else if (accepted && !burst_done) begin
                    beat_cnt_next = beat_cnt_reg + BW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge bus_clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            grant_id_reg <= M_DMA;
            last_win_reg <= M_HOST;
            beat_cnt_reg <= '0;
            err_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            grant_id_reg <= grant_id_next;
            last_win_reg <= last_win_next;
            beat_cnt_reg <= beat_cnt_next;
            err_reg      <= err_next;
        end
    end

endmodule

// File: tb/tb_sdio_bus_arb.sv
// Testbench for sdio_bus_arb: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_sdio_bus_arb;

    localparam int AW    = 17;
    localparam int BMAX  = 2;
    localparam int OUTST = 4;

    typedef struct {
        bit             rd;
        bit             wr;
        logic [AW-1:0]  addr;
        logic [7:0]     wdata;
    } cmd_t;

    logic           bus_clk = 1'b0;
    logic           rst = 1'b1;
    logic           m0_rd = 0, m0_wr = 0, m1_rd = 0, m1_wr = 0;
    logic [AW-1:0]  m0_addr = '0, m1_addr = '0;
    logic [7:0]     m0_wdata = '0, m1_wdata = '0;
    logic           s_ready = 0, s_rdata_ready = 0;
    logic [7:0]     s_rdata = '0;
    wire            m0_ready, m1_ready, m0_rdata_ready, m1_rdata_ready;
    wire [7:0]      m0_rdata, m1_rdata;
    wire            s_rd, s_wr, grant_id, busy;
    wire [AW-1:0]   s_addr;
    wire [7:0]      s_wdata;
    wire [2:0]      outst_cnt;
    wire [1:0]      err;

    always #5 bus_clk = ~bus_clk;

    sdio_bus_arb #(.AW(AW), .BURST_MAX(BMAX), .OUTST(OUTST), .PRIO0(0)) dut (
        .bus_clk(bus_clk), .rst(rst),
        .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_rdata_ready(m0_rdata_ready),
        .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_rdata_ready(m1_rdata_ready),
        .s_rd(s_rd), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ready(s_ready), .s_rdata(s_rdata), .s_rdata_ready(s_rdata_ready),
        .grant_id(grant_id), .busy(busy), .outst_cnt(outst_cnt), .err(err)
    );

    int n_pass = 0, n_fail = 0, n_total = 0;

    // Stimulus state
    cmd_t        cq0[$], cq1[$];
    cmd_t        r_cmd[2];
    bit          r_act[2];
    bit          sr, srr;
    int          ret_mode;          // 0 manual, 1 return when pending, 2 random when pending, 3 fully random
    logic [7:0]  retq[$];
    logic [7:0]  srd;

    // Reference model state (transaction level)
    bit          m_busy, m_owner, m_last;
    int          m_beats;
    bit          tags[$];
    logic [1:0]  m_err;

    // Per-cycle predictions
    bit          p_req[2], p_rd[2], p_wr[2];
    bit          e_rd, e_wr, e_rdy[2], e_rrdy[2], p_held;
    logic [AW-1:0] e_addr;
    logic [7:0]  e_wdata;

    // Observation logs
    logic [24:0] wlog[$];
    bit          own_log[$];
    logic [7:0]  rx0[$], rx1[$];
    int          rd_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_last  = 1;
        m_beats = 0;
        m_err   = 2'b00;
        tags.delete();
    endtask

    task automatic push_cmd(input int m, input bit rd, input bit wr, input int addr, input int wdata);
        cmd_t c;
        c.rd = rd; c.wr = wr; c.addr = AW'(addr); c.wdata = 8'(wdata);
        if (m == 0) cq0.push_back(c); else cq1.push_back(c);
    endtask

    function automatic bit masters_done();
        return (cq0.size() == 0) && (cq1.size() == 0) && !r_act[0] && !r_act[1];
    endfunction

    function automatic bit all_idle();
        return masters_done() && !m_busy && (tags.size() == 0);
    endfunction

    task automatic predict();
        int ow;
        for (int i = 0; i < 2; i++) begin
            p_rd[i]  = r_act[i] && r_cmd[i].rd;
            p_wr[i]  = r_act[i] && r_cmd[i].wr;
            p_req[i] = p_rd[i] || p_wr[i];
            e_rdy[i] = 0;
            e_rrdy[i] = 0;
        end
        e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0; p_held = 0;
        if (rst) model_reset();
        if (m_busy) begin
            ow      = int'(m_owner);
            p_held  = (m_beats >= BMAX) && p_req[1-ow];
            e_wr    = p_wr[ow] && !p_held;
            e_rd    = p_rd[ow] && !p_wr[ow] && (tags.size() < OUTST) && !p_held;
            e_addr  = r_cmd[ow].addr;
            e_wdata = r_cmd[ow].wdata;
            e_rdy[ow] = sr && (e_rd || e_wr);
        end
        for (int x = 0; x < 2; x++)
            e_rrdy[x] = !rst && srr && (tags.size() > 0) && (tags[0] == 1'(x));
    endtask

    task automatic update();
        int ow;
        bit w;
        if (rst) begin
            model_reset();
            r_act[0] = 0; r_act[1] = 0;
        end else begin
            ow = int'(m_owner);
            if (srr) begin
                if (tags.size() > 0) void'(tags.pop_front());
                else m_err[0] = 1'b1;
            end
            if (e_rd && sr) tags.push_back(m_owner);
            if (m_busy && p_rd[ow] && p_wr[ow]) m_err[1] = 1'b1;
            if (!m_busy) begin
                if (p_req[0] || p_req[1]) begin
                    w = (p_req[0] && p_req[1]) ? !m_last : p_req[1];
                    m_busy = 1; m_owner = w; m_last = w; m_beats = 0;
                end
            end else if (!p_req[ow]) begin
                m_beats = 0;
                if (p_req[1-ow]) begin
                    m_owner = !m_owner; m_last = m_owner;
                end else begin
                    m_busy = 0;
                end
            end else if (p_held) begin
                m_owner = !m_owner; m_last = m_owner; m_beats = 0;
            end else if (e_rdy[ow]) begin
                m_beats = (m_beats + 1 > BMAX) ? BMAX : m_beats + 1;
            end
            for (int i = 0; i < 2; i++) if (e_rdy[i]) r_act[i] = 0;
        end
    endtask

    task automatic cycle();
        @(negedge bus_clk);
        if (!r_act[0] && cq0.size() > 0) begin r_cmd[0] = cq0.pop_front(); r_act[0] = 1; end
        if (!r_act[1] && cq1.size() > 0) begin r_cmd[1] = cq1.pop_front(); r_act[1] = 1; end
        case (ret_mode)
            1: srr = (tags.size() > 0);
            2: srr = (tags.size() > 0) && ($urandom_range(0, 1) == 1);
            3: srr = ($urandom_range(0, 3) == 0);
            default: ;
        endcase
        srd = (srr && retq.size() > 0) ? retq.pop_front() : 8'($urandom);
        m0_rd = r_act[0] && r_cmd[0].rd;  m0_wr = r_act[0] && r_cmd[0].wr;
        m1_rd = r_act[1] && r_cmd[1].rd;  m1_wr = r_act[1] && r_cmd[1].wr;
        m0_addr = r_cmd[0].addr; m0_wdata = r_cmd[0].wdata;
        m1_addr = r_cmd[1].addr; m1_wdata = r_cmd[1].wdata;
        s_ready = sr; s_rdata_ready = srr; s_rdata = srd;
        #1;
        predict();
        chk("s_rd", 32'(s_rd), 32'(e_rd));
        chk("s_wr", 32'(s_wr), 32'(e_wr));
        chk("s_addr", 32'(s_addr), 32'(e_addr));
        chk("s_wdata", 32'(s_wdata), 32'(e_wdata));
        chk("m0_ready", 32'(m0_ready), 32'(e_rdy[0]));
        chk("m1_ready", 32'(m1_ready), 32'(e_rdy[1]));
        chk("m0_rdata_ready", 32'(m0_rdata_ready), 32'(e_rrdy[0]));
        chk("m1_rdata_ready", 32'(m1_rdata_ready), 32'(e_rrdy[1]));
        chk("m0_rdata", 32'(m0_rdata), 32'(srd));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("outst_cnt", 32'(outst_cnt), 32'(tags.size()));
        chk("err", 32'(err), 32'(m_err));
        if (m_busy) chk("grant_id", 32'(grant_id), 32'(m_owner));
        if (m0_ready) begin own_log.push_back(0); $display("beat  m0 rd=%0d wr=%0d addr=%05h wdata=%02h", m0_rd, m0_wr, m0_addr, m0_wdata); end
        if (m1_ready) begin own_log.push_back(1); $display("beat  m1 rd=%0d wr=%0d addr=%05h wdata=%02h", m1_rd, m1_wr, m1_addr, m1_wdata); end
        if (s_wr && s_ready) wlog.push_back({s_addr, s_wdata});
        if (s_rd && s_ready) rd_acc++;
        if (m0_rdata_ready) begin rx0.push_back(m0_rdata); $display("rdata m0 %02h", m0_rdata); end
        if (m1_rdata_ready) begin rx1.push_back(m1_rdata); $display("rdata m1 %02h", m1_rdata); end
        @(posedge bus_clk);
        update();
    endtask

    task automatic run_until_idle(input string tag, input int maxc);
        int n = 0;
        while (!all_idle() && n < maxc) begin cycle(); n++; end
        chk({tag, "_idle"}, 32'(all_idle()), 32'd1);
    endtask

    task automatic run_until_masters(input string tag, input int maxc);
        int n = 0;
        while (!masters_done() && n < maxc) begin cycle(); n++; end
        chk({tag, "_done"}, 32'(masters_done()), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   peak;
        bit   exp_own[8];
        cmd_t c;

        model_reset();
        sr = 1; srr = 0; ret_mode = 0;
        r_act[0] = 0; r_act[1] = 0;

        // Reset state
        cycle(); cycle();
        #1;
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        #1 rst = 0;

        // T1: m0 writes 4 beats, grant one cycle after request
        wlog.delete();
        for (int k = 0; k < 4; k++) push_cmd(0, 0, 1, 'h100 + k, 'hA0 + k);
        cycle();
        #1 chk("t1_grant_latency", 32'(busy), 32'd1);
        run_until_idle("t1", 30);
        chk("t1_nwr", 32'(wlog.size()), 32'd4);
        for (int k = 0; k < 4 && k < wlog.size(); k++)
            chk("t1_slave_wr", 32'(wlog[k]), 32'({17'(17'h100 + k), 8'(8'hA0 + k)}));

        // T2: both request, last winner m0 -> m1 first, owner alternates every 2 beats
        own_log.delete();
        for (int k = 0; k < 4; k++) begin
            push_cmd(0, 0, 1, 'h400 + k, 'h10 + k);
            push_cmd(1, 0, 1, 'h500 + k, 'h20 + k);
        end
        run_until_idle("t2", 60);
        exp_own = '{1, 1, 0, 0, 1, 1, 0, 0};
        chk("t2_nbeats", 32'(own_log.size()), 32'd8);
        for (int k = 0; k < 8 && k < own_log.size(); k++)
            chk("t2_owner", 32'(own_log[k]), 32'(exp_own[k]));

        // T3: 5 reads with slave withholding data -> 5th stalls at OUTST
        ret_mode = 0; srr = 0; rd_acc = 0; peak = 0;
        for (int k = 0; k < 5; k++) push_cmd(0, 1, 0, 'h200 + k, 0);
        for (int k = 0; k < 9; k++) begin
            cycle();
            #1 if (int'(outst_cnt) > peak) peak = int'(outst_cnt);
        end
        chk("t3_peak", 32'(peak), 32'd4);
        chk("t3_reads_before_return", 32'(rd_acc), 32'd4);
        srr = 1; cycle(); srr = 0;
        chk("t3_full_blocks_push", 32'(rd_acc), 32'd4);
        cycle();
        chk("t3_fifth_read", 32'(rd_acc), 32'd5);
        ret_mode = 1;
        run_until_idle("t3", 40);
        ret_mode = 0; srr = 0;

        // T4: m0 two reads then m1 two reads, data routed by tag
        rx0.delete(); rx1.delete();
        push_cmd(0, 1, 0, 'h600, 0); push_cmd(0, 1, 0, 'h601, 0);
        run_until_masters("t4_m0", 20);
        push_cmd(1, 1, 0, 'h700, 0); push_cmd(1, 1, 0, 'h701, 0);
        run_until_masters("t4_m1", 20);
        retq.push_back(8'h11); retq.push_back(8'h22); retq.push_back(8'h33); retq.push_back(8'h44);
        ret_mode = 1;
        run_until_idle("t4", 30);
        ret_mode = 0; srr = 0;
        chk("t4_m0_count", 32'(rx0.size()), 32'd2);
        chk("t4_m1_count", 32'(rx1.size()), 32'd2);
        if (rx0.size() == 2) begin chk("t4_m0_d0", 32'(rx0[0]), 32'h11); chk("t4_m0_d1", 32'(rx0[1]), 32'h22); end
        if (rx1.size() == 2) begin chk("t4_m1_d0", 32'(rx1[0]), 32'h33); chk("t4_m1_d1", 32'(rx1[1]), 32'h44); end

        // T5: orphan read data, then rd&wr collision
        srr = 1; cycle(); srr = 0;
        #1 chk("t5_orphan_err", 32'(err), 32'd1);
        push_cmd(0, 1, 1, 'h300, 'h5A);
        run_until_idle("t5", 20);
        #1 chk("t5_rdwr_err", 32'(err), 32'd3);

        // T6: reset with two reads in flight and a stalled write
        push_cmd(0, 1, 0, 'h800, 0); push_cmd(0, 1, 0, 'h801, 0);
        run_until_masters("t6_rd", 20);
        sr = 0;
        push_cmd(0, 0, 1, 'h900, 'h77);
        cycle(); cycle();
        #1 chk("t6_pre_outst", 32'(outst_cnt), 32'd2);
        #1 rst = 1;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_s_wr", 32'(s_wr), 32'd0);
        chk("t6_rst_s_rd", 32'(s_rd), 32'd0);
        chk("t6_rst_outst", 32'(outst_cnt), 32'd0);
        chk("t6_rst_err", 32'(err), 32'd0);
        chk("t6_rst_m0_ready", 32'(m0_ready), 32'd0);
        model_reset();
        r_act[0] = 0; r_act[1] = 0; cq0.delete(); cq1.delete();
        cycle(); cycle();
        #2 rst = 0;
        sr = 1;
        srr = 1; cycle(); srr = 0;
        #1 chk("t6_late_rdata_err", 32'(err), 32'd1);
        push_cmd(0, 0, 1, 'hA00, 'h99);
        cycle();
        #1 chk("t6_regrant", 32'(busy), 32'd1);
        run_until_idle("t6", 20);

        // Random traffic against the model
        ret_mode = 3;
        for (int n = 0; n < 400; n++) begin
            for (int m = 0; m < 2; m++) begin
                if (!r_act[m] && ((m == 0) ? cq0.size() : cq1.size()) == 0 && $urandom_range(0, 2) == 0) begin
                    c.addr  = AW'($urandom);
                    c.wdata = 8'($urandom);
                    case ($urandom_range(0, 9))
                        0, 1, 2, 3: begin c.rd = 1; c.wr = 0; end
                        9:          begin c.rd = 1; c.wr = 1; end
                        default:    begin c.rd = 0; c.wr = 1; end
                    endcase
                    if (m == 0) cq0.push_back(c); else cq1.push_back(c);
                end
            end
            sr = ($urandom_range(0, 3) != 0);
            cycle();
        end
        sr = 1; ret_mode = 1;
        run_until_idle("final", 200);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
